// File: rtl/ser_pkg.sv
// ser_pkg: definitions shared by the serial word source slice.
//   ser_state_t  : shifter state (IDLE = line parked, SHIFT = data bit on line)
//   SER_WIDTH    : default parallel word width
//   SER_IDLE_BIT : default level held on the serial line between words
package ser_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } ser_state_t;

    localparam int SER_WIDTH    = 8;
    localparam bit SER_IDLE_BIT = 1'b1;

endpackage

// File: rtl/serial_word_source_if.sv
// serial_word_source_if: word handshake in, serial bit stream out.
//   din       : parallel word (WIDTH bits)
//   din_valid : din carries a word this cycle
//   din_ready : source can take din this cycle
//   x         : serial bit to the sequence detector
//   x_valid   : x carries a data bit this cycle
//   busy      : shifter active or holding register full
// slave modport is the source block; master modport is the upstream/downstream side.
interface serial_word_source_if
    import ser_pkg::*;
#(
    parameter int WIDTH = SER_WIDTH
) ();

    logic [WIDTH-1:0] din;
    logic             din_valid;
    logic             din_ready;
    logic             x;
    logic             x_valid;
    logic             busy;

    modport slave (
        input  din,
        input  din_valid,
        output din_ready,
        output x,
        output x_valid,
        output busy
    );

    modport master (
        output din,
        output din_valid,
        input  din_ready,
        input  x,
        input  x_valid,
        input  busy
    );

endinterface

// File: rtl/ser_hold_reg.sv
// ser_hold_reg: one-entry holding register in front of the shifter.
//   clk, reset : clock, synchronous active-high reset
//   din        : incoming word
//   din_valid  : incoming word valid
//   shifting   : shifter is in SHIFT
//   last_bit   : shifter bit counter is at zero (last bit on the line)
//   hold       : buffered word
//   hold_full  : hold contains a word not yet moved into the shifter
//   din_ready  : a word can be accepted this cycle
//   drain      : hold moves into the shifter at the coming edge
module ser_hold_reg
    import ser_pkg::*;
#(
    parameter int WIDTH = SER_WIDTH
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] din,
    input  logic             din_valid,
    input  logic             shifting,
    input  logic             last_bit,
    output logic [WIDTH-1:0] hold,
    output logic             hold_full,
    output logic             din_ready,
    output logic             drain
);

    logic accept;

    // The shifter takes the held word when it is idle or about to finish
    // its last bit, so consecutive words stream without an idle cycle.
    assign drain     = hold_full & (~shifting | last_bit);

    // Ready comes only from registered state (and reset), never from
    // din_valid, so upstream sees no combinational loop through us.
    assign din_ready = ~reset & (~hold_full | drain);
    assign accept    = din_valid & din_ready;

    always_ff @(posedge clk) begin
        if (reset) begin
            hold_full <= 1'b0;
        end else if (accept) begin
            // A refill in the drain cycle keeps hold_full set.
            hold_full <= 1'b1;
        end else if (drain) begin
            hold_full <= 1'b0;
        end
    end

    // Data path only; its contents are qualified by hold_full.
    always_ff @(posedge clk) begin
        if (accept) begin
            hold <= din;
        end
    end

endmodule

// File: rtl/serial_word_source.sv
// serial_word_source: parallel-to-serial front end for the sequence detector.
// Buffers one word behind the shifter and emits one bit per clock on x.
//   clk, reset : clock, synchronous active-high reset
//   bus        : serial_word_source_if.slave (din/din_valid/din_ready in,
//                x/x_valid/busy out)
// Parameters:
//   WIDTH     : word width (>= 2)
//   MSB_FIRST : 1 shifts bit WIDTH-1 first, 0 shifts bit 0 first
//   IDLE_BIT  : level on x whenever x_valid is low
//
// state | meaning
// ------+--------------------------------------------------------------
// IDLE  | line parked at IDLE_BIT, waiting for a word in hold
// SHIFT | shreg output bit on x; cnt counts bits remaining after this one
module serial_word_source
    import ser_pkg::*;
#(
    parameter int WIDTH     = SER_WIDTH,
    parameter bit MSB_FIRST = 1'b1,
    parameter bit IDLE_BIT  = SER_IDLE_BIT
) (
    input  logic                 clk,
    input  logic                 reset,
    serial_word_source_if.slave  bus
);

    localparam int CNT_W = $clog2(WIDTH);

    ser_state_t       state_q, state_d;
    logic [WIDTH-1:0] shreg_q, shreg_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    logic [WIDTH-1:0] hold;
    logic             hold_full;
    logic             drain;
    logic             shifting;
    logic             last_bit;
    logic             out_bit;

    assign shifting = (state_q == SHIFT);
    assign last_bit = (cnt_q == '0);

    ser_hold_reg #(
        .WIDTH (WIDTH)
    ) u_hold (
        .clk       (clk),
        .reset     (reset),
        .din       (bus.din),
        .din_valid (bus.din_valid),
        .shifting  (shifting),
        .last_bit  (last_bit),
        .hold      (hold),
        .hold_full (hold_full),
        .din_ready (bus.din_ready),
        .drain     (drain)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            shreg_q <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            shreg_q <= shreg_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        shreg_d = shreg_q;
        cnt_d   = cnt_q;
        if (drain) begin
            shreg_d = hold;
            cnt_d   = CNT_W'(WIDTH - 1);
            state_d = SHIFT;
        end else if (state_q == SHIFT) begin
            if (cnt_q != '0) begin
                // Move the next bit into the output position.
                if (MSB_FIRST) begin
                    shreg_d = {shreg_q[WIDTH-2:0], 1'b0};
                end else begin
                    shreg_d = {1'b0, shreg_q[WIDTH-1:1]};
                end
                cnt_d = cnt_q - CNT_W'(1);
            end else begin
                state_d = IDLE;
            end
        end
    end

    // Outputs depend on registers only; din/din_valid never reach x.
    assign out_bit     = MSB_FIRST ? shreg_q[WIDTH-1] : shreg_q[0];
    assign bus.x       = shifting ? out_bit : IDLE_BIT;
    assign bus.x_valid = shifting;
    assign bus.busy    = shifting | hold_full;

endmodule

// File: doc/serial_word_source.md
# serial_word_source

Parallel-to-serial front end for the sequence-detector path. Accepts WIDTH-bit words over a valid/ready handshake, buffers one word, and shifts bits out one per clock on `x`, which feeds the detector's serial `x` input directly. Back-to-back words stream with no idle gap. Between words the line holds a fixed idle level.

## Interface
- WIDTH, 8: word width; legal values are ≥ 2.
- MSB_FIRST, 1: 1 shifts bit WIDTH-1 first; 0 shifts bit 0 first.
- IDLE_BIT, 1: level driven on `x` whenever `x_valid` = 0.

- clk  in  1  single clock; all state changes on posedge.
- reset  in  1  synchronous, active-high; sampled on posedge clk.
- din  in  WIDTH  parallel word.
- din_valid  in  1  `din` is valid this cycle.
- din_ready  out  1  block can accept `din` this cycle; transfer happens when `din_valid` & `din_ready` are high at a posedge.
- x  out  1  serial bit stream to the detector.
- x_valid  out  1  `x` carries a data bit this cycle.
- busy  out  1  shifter active or holding register full.

## Operation
- Storage: one holding register (`hold`, `hold_full`) plus a shift register (`shreg`) and a bit counter `cnt` of width $clog2(WIDTH).
- FSM states:
  - IDLE: `x` = IDLE_BIT, `x_valid` = 0.
  - SHIFT: `x` = current output bit of `shreg`, `x_valid` = 1.
- Drain condition, `drain`: (IDLE & hold_full) | (SHIFT & cnt == 0 & hold_full).
  - On drain: `shreg` <= hold, `cnt` <= WIDTH-1, state <= SHIFT, `hold_full` cleared unless refilled in the same cycle.
- In SHIFT with cnt ≠ 0: shift `shreg` toward the output end and decrement `cnt`.
- In SHIFT with cnt == 0 and `hold_full` = 0: state <= IDLE.
- `din_ready` = ~reset & (~hold_full | drain).
  - Depends only on registered state, never on `din_valid`.
- Simultaneous accept and drain: `hold` takes the new word, `shreg` takes the old word, and `hold_full` stays 1.
- `busy` = (state == SHIFT) | hold_full.
- Reset (any cycle, including mid-word): state <= IDLE, `hold_full` <= 0, `cnt` <= 0. The partial word is discarded and never resumed.
  - While `reset` is high, `din_ready` = 0.

## Timing
- Values after reset: `x` = IDLE_BIT, `x_valid` = 0, `busy` = 0. `din_ready` = 1 once `reset` deasserts.
- Latency: a word accepted at edge N loads `shreg` at edge N+1. Its first bit appears after edge N+1; its last bit appears after edge N+WIDTH and drops after edge N+WIDTH+1 (if no further word is pending).
- Throughput: one bit per clock, sustained indefinitely if upstream presents the next word before the last-bit cycle of the current word.
- A single word occupies WIDTH consecutive `x_valid` cycles with no gaps.
- A stall on `din_valid` inserts IDLE_BIT cycles. This is the only way gaps occur.
- `x` and `x_valid` are driven only from registers; there is no combinational path from `din` or `din_valid` to them.

## Structure
- Shared package `ser_pkg`:
  - state enum `ser_state_t` {IDLE, SHIFT};
  - default width constant `SER_WIDTH` = 8;
  - default idle level constant `SER_IDLE_BIT` = 1.
- One natural sub-module, `ser_hold_reg`: the one-entry holding register with `hold_full`, `din_ready`, and `drain` logic. The top module holds the FSM, `shreg`, and `cnt`.

## Test plan
- Reset: assert `reset` for 2 cycles with `din_valid` = 1. Required: `x` = 1, `x_valid` = 0, `busy` = 0, `din_ready` = 0 during reset; `din_ready` = 1 on the first cycle after reset and no word accepted during reset.
- Single word, MSB_FIRST = 1: din = 8'h66 accepted at edge N. Required: `x_valid` high for exactly cycles N+1..N+8 with `x` = 0,1,1,0,0,1,1,0; the downstream detector sees 0110 twice.
- Back-to-back: 8'h0F then 8'hF0, `din_valid` held high. Required: 16 consecutive `x_valid` cycles, `x` = 00001111 11110000; the second word is accepted while the first shifts; `din_ready` drops while hold is full and rises on the last-bit cycle of the first word.
- LSB first, MSB_FIRST = 0: din = 8'h01. Required: `x` = 1 then seven 0s, then IDLE_BIT.
- Backpressure: present 8'hAA while a word is mid-shift and `hold` is full. Required: `din_ready` = 0 until the last-bit cycle of the shifting word; 8'hAA is accepted there and streams with no gap.
- Reset mid-word: assert `reset` after 3 bits of 8'hC3 are shifted, with 8'h55 in `hold`. Required: the next cycle shows `x_valid` = 0, `busy` = 0, `x` = IDLE_BIT; neither word resumes.
